// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer.
// Holds the retire flag bit positions, the trace record layout and the
// default buffer sizing. The trace filter helper is only referenced when
// the design is built with TRACE_FILTER_EN defined.
package trace_pkg;

  localparam int FLAGS_W      = 9;
  localparam int FLG_REGWRITE = 0;
  localparam int FLG_REGDEST  = 1;
  localparam int FLG_JUMP     = 2;
  localparam int FLG_JAL      = 3;
  localparam int FLG_BRANCH   = 4;
  localparam int FLG_MEMTOREG = 5;
  localparam int FLG_MEMWRITE = 6;
  localparam int FLG_ALUSRC   = 7;
  localparam int FLG_ZERO     = 8;

  localparam int DEPTH_DEF = 16;
  localparam int SEQ_W_DEF = 16;

  // Record layout as stored in the FIFO, most significant field first.
  typedef struct packed {
    logic [31:0]          pc;
    logic [FLAGS_W-1:0]   flags;
    logic [SEQ_W_DEF-1:0] seq;
  } trace_rec_t;

  // True for retires that change control flow or memory state.
  function automatic logic is_flow_event(input logic [FLAGS_W-1:0] f);
    return f[FLG_JUMP] | f[FLG_JAL] | (f[FLG_BRANCH] & f[FLG_ZERO]) | f[FLG_MEMWRITE];
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with registered storage.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, wr_data     write request and data; ignored when full unless a
//                     pop happens in the same cycle
//   pop, rd_data      read request and head data; rd_data reads 0 when empty
//   count             occupancy, 0..DEPTH
//   full, empty       derived from count
// DEPTH must be a power of two so the pointers wrap naturally.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures the per-instruction retire view of the
// core, tags each retire with a sequence number and streams the records
// out over valid/ready. Records that arrive while the buffer is full are
// dropped and counted; the gap in out_seq shows where.
// Build option: TRACE_FILTER_EN keeps only jumps, jals, taken branches and
// stores; without it every retire is captured.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid, in_pc, in_flags       retire view from the core
//   out_valid, out_ready            head record handshake
//   out_pc, out_flags, out_seq      head record (0 while empty)
//   count                           occupancy
//   overflow                        sticky drop indicator
//   drop_cnt                        saturating dropped-record counter
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int SEQ_W  = SEQ_W_DEF,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [31:0]            in_pc,
  input  logic [FLAGS_W-1:0]     in_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [FLAGS_W-1:0]     out_flags,
  output logic [SEQ_W-1:0]       out_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
);

  // Same field order as trace_rec_t, with the seq field sized by SEQ_W.
  localparam int REC_W = $bits(trace_rec_t) - SEQ_W_DEF + SEQ_W;

  logic [SEQ_W-1:0] seq_q;
  logic [REC_W-1:0] wr_data;
  logic [REC_W-1:0] rd_data;
  logic             eligible;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             drop;

`ifdef TRACE_FILTER_EN
  assign eligible = in_valid && is_flow_event(in_flags);
`else
  assign eligible = in_valid;
`endif

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // A full buffer still accepts a record when the head leaves this cycle.
  assign push      = eligible && (!fifo_full || pop);
  assign drop      = eligible && fifo_full && !pop;
  assign wr_data   = {in_pc, in_flags, seq_q};

  assign {out_pc, out_flags, out_seq} = rd_data;

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Every retire consumes a sequence number, stored or not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_q    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (in_valid) seq_q <= seq_q + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [8:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [8:0]  out_flags;
  logic [15:0] out_seq;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(16), .SEQ_W(16), .DROP_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_flags  (in_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_flags (out_flags),
    .out_seq   (out_seq),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [8:0]  fl;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [8:0]  efl;
    logic [15:0] eseq;
    logic [4:0]  ecnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample just after the edge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [8:0] fl, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_flags  = fl;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [8:0] fl,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [8:0] efl, input logic [15:0] eseq, input logic [4:0] ecnt);
    vec_t r;
    r.v = v; r.pc = pc; r.fl = fl; r.rdy = rdy;
    r.ev = ev; r.epc = epc; r.efl = efl; r.eseq = eseq; r.ecnt = ecnt;
    return r;
  endfunction

  initial begin
    logic [8:0]  filt_fl [5];
    logic [15:0] filt_seq [5];
    int          filt_n;

    // basic order with ready high, then backpressure and drain
    tbl[0]  = mk(1, 32'h000, 9'h004, 1,  1, 32'h000, 9'h004, 0, 1);
    tbl[1]  = mk(1, 32'h004, 9'h00C, 1,  1, 32'h004, 9'h00C, 1, 1);
    tbl[2]  = mk(1, 32'h008, 9'h044, 1,  1, 32'h008, 9'h044, 2, 1);
    tbl[3]  = mk(1, 32'h00C, 9'h114, 1,  1, 32'h00C, 9'h114, 3, 1);
    tbl[4]  = mk(1, 32'h010, 9'h004, 1,  1, 32'h010, 9'h004, 4, 1);
    tbl[5]  = mk(0, 32'h000, 9'h000, 1,  0, 32'h000, 9'h000, 0, 0);
    tbl[6]  = mk(1, 32'h100, 9'h008, 0,  1, 32'h100, 9'h008, 5, 1);
    tbl[7]  = mk(1, 32'h104, 9'h004, 0,  1, 32'h100, 9'h008, 5, 2);
    tbl[8]  = mk(1, 32'h108, 9'h040, 0,  1, 32'h100, 9'h008, 5, 3);
    tbl[9]  = mk(0, 32'h000, 9'h000, 0,  1, 32'h100, 9'h008, 5, 3);
    tbl[10] = mk(0, 32'h000, 9'h000, 1,  1, 32'h104, 9'h004, 6, 2);
    tbl[11] = mk(0, 32'h000, 9'h000, 1,  1, 32'h108, 9'h040, 7, 1);
    tbl[12] = mk(0, 32'h000, 9'h000, 1,  0, 32'h000, 9'h000, 0, 0);

    do_reset();
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_out", {out_pc, out_flags, out_seq}, 0);

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].v, tbl[i].pc, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
      chk($sformatf("tbl%0d_flags", i), out_flags, tbl[i].efl);
      chk($sformatf("tbl%0d_seq", i), out_seq, tbl[i].eseq);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].ecnt);
    end

    // overflow: 19 retires into a stalled 16-entry buffer
    do_reset();
    for (int i = 0; i < 19; i++) cyc(1, 32'(i * 4), 9'h004, 0);
    chk("ovf_count", count, 16);
    chk("ovf_drop", drop_cnt, 3);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head_seq", out_seq, 0);
    chk("ovf_head_pc", out_pc, 0);

    // full buffer, simultaneous push and pop
    cyc(1, 32'hAAA0, 9'h004, 1);
    chk("pp_count", count, 16);
    chk("pp_drop", drop_cnt, 3);
    chk("pp_head_seq", out_seq, 1);
    chk("pp_head_pc", out_pc, 4);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_valid", i), out_valid, 1);
      chk($sformatf("drain%0d_seq", i), out_seq, (i < 15) ? 16'(i + 1) : 16'd19);
      chk($sformatf("drain%0d_pc", i), out_pc, (i < 15) ? 32'((i + 1) * 4) : 32'hAAA0);
      cyc(0, 0, 0, 1);
    end
    chk("drain_count", count, 0);
    chk("drain_valid", out_valid, 0);

    // reset mid-stream with 7 records buffered and overflow set
    for (int i = 0; i < 7; i++) cyc(1, 32'h400 + 32'(i * 4), 9'h004, 0);
    chk("mid_count", count, 7);
    chk("mid_valid", out_valid, 1);
    rst_n = 1'b0;
    cyc(1, 32'h500, 9'h004, 0);
    rst_n = 1'b1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    cyc(1, 32'h600, 9'h004, 0);
    chk("mid_first_seq", out_seq, 0);
    chk("mid_first_pc", out_pc, 32'h600);
    chk("mid_first_count", count, 1);

    // filter: ALU, branch not taken, branch taken, jal, store
    do_reset();
    filt_fl[0] = 9'h001; filt_fl[1] = 9'h010; filt_fl[2] = 9'h110;
    filt_fl[3] = 9'h008; filt_fl[4] = 9'h040;
    for (int i = 0; i < 5; i++) cyc(1, 32'(i * 4), filt_fl[i], 0);
`ifdef TRACE_FILTER_EN
    filt_n = 3;
    filt_seq[0] = 2; filt_seq[1] = 3; filt_seq[2] = 4; filt_seq[3] = 0; filt_seq[4] = 0;
`else
    filt_n = 5;
    filt_seq[0] = 0; filt_seq[1] = 1; filt_seq[2] = 2; filt_seq[3] = 3; filt_seq[4] = 4;
`endif
    chk("filt_count", count, 5'(filt_n));
    for (int i = 0; i < filt_n; i++) begin
      chk($sformatf("filt%0d_seq", i), out_seq, filt_seq[i]);
      chk($sformatf("filt%0d_pc", i), out_pc, 32'(filt_seq[i]) * 4);
      cyc(0, 0, 0, 1);
    end
    chk("filt_empty", out_valid, 0);

    // saturation and sequence wrap: 65557 retires, 65541 of them dropped
    do_reset();
    for (int i = 0; i < 65557; i++) cyc(1, 32'h800, 9'h004, 0);
    chk("sat_drop", drop_cnt, 16'hFFFF);
    chk("sat_overflow", overflow, 1);
    chk("sat_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("sat_drain%0d_seq", i), out_seq, 16'(i));
      cyc(0, 0, 0, 1);
    end
    cyc(1, 32'h700, 9'h004, 0);
    chk("wrap_seq", out_seq, 16'd21);
    chk("wrap_pc", out_pc, 32'h700);
    chk("wrap_drop_hold", drop_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the single-cycle processor top.
- Consumes the per-instruction retire view (PC plus decoded control flags) and buffers it into a small FIFO.
- Streams the buffered records out over a valid/ready handshake to a trace sink (bench logger or debug port).
- Gives verification a lossless, in-order instruction trace with explicit drop accounting.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- SEQ_W, 16, retire sequence number width.
- DROP_W, 16, dropped-record counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  an instruction retires this cycle; tied high for the single-cycle core.
- in_pc  in  32  PC of the retiring instruction.
- in_flags  in  9  {zerodetect, ALUsrc, MemWrite, MemToReg, branch, jal, jump, regDest, regWrite}; bit 0 = regWrite.
- out_valid  out  1  head record available.
- out_ready  in  1  sink accepts the head record.
- out_pc  out  32  head record PC.
- out_flags  out  9  head record flags.
- out_seq  out  SEQ_W  retire sequence number of the head record.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set on the first dropped record.
- drop_cnt  out  DROP_W  number of dropped records, saturating.

Behaviour:
- Reset (rst_n low at a clk edge):
  - FIFO is emptied.
  - count=0, out_valid=0, overflow=0, drop_cnt=0, sequence counter=0.
  - out_pc, out_flags and out_seq read 0 while empty.
  - Reset mid-stream discards all buffered records. No partial handshake survives.
- Sequence counter:
  - Increments by 1 on every cycle with in_valid=1, whether the record is captured, filtered or dropped.
  - Wraps modulo 2^SEQ_W.
  - A captured record carries the pre-increment value. The first retire after reset has seq 0.
- Capture:
  - A record is eligible when in_valid=1 and it passes the filter (see Optional Feature).
  - An eligible record is written at the clk edge when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
- Latency: a record captured at edge N is visible on out_* with out_valid=1 after edge N, provided the FIFO was empty. There is no combinational path from in_* to out_*.
- Pop:
  - Occurs when out_valid && out_ready at the clk edge.
  - out_* present the head entry from registered storage.
  - out_valid = (count != 0).
  - out_pc, out_flags and out_seq hold stable while out_valid=1 and out_ready=0.
- Count:
  - Simultaneous push and pop leave count unchanged.
  - Push only: +1. Pop only: -1.
  - count never exceeds DEPTH and never underflows. out_ready while empty has no effect.
- Drop: an eligible record that cannot be written sets overflow and increments drop_cnt.
  - drop_cnt saturates at all-ones.
  - overflow clears only on reset.
  - Dropped records consume a sequence number, so gaps in out_seq identify the loss.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from count.

Optional Feature:
- Macro: TRACE_FILTER_EN.
- Defined: a record is eligible only if it changes control flow or memory state: jump | jal | (branch & zerodetect) | MemWrite. All other retires increment the sequence counter but are not stored.
- Undefined: every in_valid cycle is eligible (full trace).
- Port list is identical in both builds.

Decomposition:
- Shared package trace_pkg holds:
  - the flag bit-index localparams (FLG_REGWRITE=0 … FLG_ZERO=8) and FLAGS_W=9;
  - a packed struct trace_rec_t {pc[31:0], flags[8:0], seq};
  - the default DEPTH.
- One sub-module is natural: trace_fifo.
  - Generic synchronous FIFO parameterised on width and depth, with push, pop, count and full/empty.
  - Instantiated once with the width of trace_rec_t.
  - The top handles filtering, sequencing and drop accounting.

Test Plan:
- Basic order: reset, then 5 retires at PC 0x00, 0x04, 0x08, 0x0C, 0x10 with out_ready=1 → 5 records in order, seq 0..4, each appearing 1 cycle after capture; count returns to 0.
- Backpressure stability: out_ready=0, push 3 records → out_valid=1, out_pc held at the first PC for the whole stall, count=3. Then out_ready=1 → drains in order over 3 cycles.
- Overflow and simultaneous push/pop:
  - out_ready=0, DEPTH+3 retires → count=16, drop_cnt=3, overflow=1.
  - After draining, out_seq runs 0..15 and the next capture carries seq 19.
  - At count=16, push and pop in the same cycle → record accepted, count stays 16, drop_cnt unchanged.
- Saturation and wrap: force 2^SEQ_W+2 retires → out_seq wraps to 0. Separately, drop 2^DROP_W+5 records → drop_cnt holds 0xFFFF.
- Reset mid-stream: with count=7 and out_valid=1, assert rst_n=0 for one edge → count=0, out_valid=0, overflow=0, next capture has seq 0.
- Filter (with TRACE_FILTER_EN):
  - Retire sequence ALU, branch not taken (branch=1, zerodetect=0), branch taken, jal, MemWrite → only 3 records stored, seqs 2, 3, 4.
  - Without the macro → all 5 records stored.
